mem_pipe: RTL

- Parametrised single-port synchronous memory; next generation of the 32x8 mbus memory.
- Generalised in address and data width, with byte-enable writes and a configurable read latency.
- Valid/ready request handshake and an optional hardware zero-fill after reset.
- Sits behind the memory bus as the storage target for the test program and later bus masters.

---
 rtl/mem_pipe_pkg.sv | 9 +
 rtl/mem_pipe_if.sv | 27 ++
 rtl/mem_rd_pipe.sv | 50 +++++
 rtl/mem_pipe.sv | 97 +++++++++
 4 files changed

// File: rtl/mem_pipe_pkg.sv
// Shared types and limits for the mem_pipe single-port memory.
package mem_pipe_pkg;

   typedef enum logic {INIT, IDLE} mem_state_t;
   typedef enum logic {MEM_READ, MEM_WRITE} mem_op_t;

   localparam int MAX_RD_LATENCY = 4;

endpackage

// File: rtl/mem_pipe_if.sv
// Request/response bus between a requester (master) and the mem_pipe storage (slave).
interface mem_pipe_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8
);

   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [DATA_WIDTH-1:0]   req_wdata;
   logic [DATA_WIDTH/8-1:0] req_be;
   logic                    rsp_valid;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   logic                    init_done;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, init_done
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, init_done
   );

endinterface

// File: rtl/mem_rd_pipe.sv
// Read-response delay line: each accepted read emerges RD_LATENCY cycles later;
// the output data word holds its last value between responses.
module mem_rd_pipe
   import mem_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata
);

   if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
      $error("mem_rd_pipe: RD_LATENCY must be within 1..%0d", MAX_RD_LATENCY);
   end

   logic [RD_LATENCY-1:0] vld_q, vld_d;
   logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];
   logic [DATA_WIDTH-1:0] dat_d [RD_LATENCY];

   always_comb begin
      vld_d    = '0;
      dat_d    = dat_q;
      vld_d[0] = in_valid;
      if (in_valid) dat_d[0] = in_data;
      // A stage only takes new data when a valid word moves into it, so the last stage holds.
      for (int i = 1; i < RD_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign rsp_valid = vld_q[RD_LATENCY-1];
   assign rsp_rdata = dat_q[RD_LATENCY-1];

endmodule

// File: rtl/mem_pipe.sv
// Parametrised single-port memory with byte-enable writes, pipelined reads
// and an optional zero-fill sequence after reset.
module mem_pipe
   import mem_pipe_pkg::*;
#(
   parameter int ADDR_WIDTH    = 5,
   parameter int DATA_WIDTH    = 8,
   parameter int RD_LATENCY    = 1,
   parameter int INIT_ON_RESET = 1
) (
   input  logic     clk,
   input  logic     rst_,
   mem_pipe_if.slave bus
);

   localparam int DEPTH    = 2 ** ADDR_WIDTH;
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("mem_pipe: DATA_WIDTH must be a non-zero multiple of 8");
   end

   mem_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  ready_q, ready_d;
   logic                  done_q, done_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   mem_op_t op;
   logic    accept, wr_en, rd_en, fill_en;

   assign op      = mem_op_t'(bus.req_write);
   assign accept  = bus.req_valid && ready_q;
   assign wr_en   = accept && (op == MEM_WRITE);
   assign rd_en   = accept && (op == MEM_READ);
   assign fill_en = rst_ && (state_q == INIT) && (INIT_ON_RESET != 0);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      done_d  = done_q;
      if (state_q == INIT) begin
         if (INIT_ON_RESET != 0) cnt_d = cnt_q + 1'b1;
         // Leaving INIT on the last fill write makes ready/done rise on the first IDLE cycle.
         if (INIT_ON_RESET == 0 || &cnt_q) begin
            state_d = IDLE;
            ready_d = 1'b1;
            done_d  = 1'b1;
         end
      end
   end

   // NOTE: state flops use non-blocking assignments only; blocking is reserved for always_comb.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= INIT;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   // NOTE: the array has no reset term so it maps onto RAM; clearing it is the fill sequence's job.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         mem[cnt_q] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (bus.req_be[b]) mem[bus.req_addr][8*b +: 8] <= bus.req_wdata[8*b +: 8];
         end
      end
   end

   mem_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_pipe (
      .clk       (clk),
      .rst_      (rst_),
      .in_valid  (rd_en),
      .in_data   (mem[bus.req_addr]),
      .rsp_valid (bus.rsp_valid),
      .rsp_rdata (bus.rsp_rdata)
   );

   assign bus.req_ready = ready_q;
   assign bus.init_done = done_q;

endmodule
